// File: rtl/alg_pkg.sv
// Algorithm-side constants shared by the R-peak detector and its consumers.
package alg_pkg;

    // Width of one R-peak sample number produced by the detector.
    localparam int CTR_WIDTH = 32;

endpackage

// File: rtl/uart_pkg.sv
// UART-side types and helpers for the R-peak frame streamer.
package uart_pkg;

    // Streamer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT_DATA,
        ST_LOAD,
        ST_STROBE,
        ST_GUARD,
        ST_WAIT_TX,
        ST_DONE
    } streamer_state_e;

    // Default start-of-frame marker.
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Frame length in bytes: SOF, seq, ceil(ctr_width/8) data bytes, checksum.
    function automatic int frame_bytes(input int ctr_width);
        return (ctr_width + 7) / 8 + 3;
    endfunction

endpackage

// File: rtl/rpeak_streamer.sv
// Pops R-peak sample numbers from the output FIFO and sends each as a
// framed byte sequence (SOF, seq, data MSB-first, XOR checksum) to a UART.
module rpeak_streamer
    import uart_pkg::*;
#(
    parameter int         CTR_WIDTH = 32,
    parameter logic [7:0] SOF_BYTE  = SOF_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_pop,
    input  logic [CTR_WIDTH-1:0] i_fifo_rdata,
    input  logic                 i_fifo_rdata_valid,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_data_valid,
    input  logic                 i_tx_busy,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic [7:0]           o_seq
);

    localparam int NB    = (CTR_WIDTH + 7) / 8;
    localparam int FLEN  = frame_bytes(CTR_WIDTH);
    localparam int IDX_W = $clog2(FLEN);

    localparam logic [IDX_W-1:0] IDX_SOF  = '0;
    localparam logic [IDX_W-1:0] IDX_SEQ  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FLEN - 1);

    if (CTR_WIDTH < 8 || CTR_WIDTH > 32) begin : g_bad_width
        $error("rpeak_streamer: CTR_WIDTH must be in 8..32");
    end

    streamer_state_e  state, state_nxt;
    logic [NB*8-1:0]  shreg;
    logic [IDX_W-1:0] byte_idx;
    logic [7:0]       csum;
    logic [7:0]       tx_data;
    logic [7:0]       seq;
    logic [7:0]       cur_byte;

    // Select the frame byte addressed by byte_idx; data bytes come off the top of the shift register.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        cur_byte = shreg[NB*8-1 -: 8];
        if (byte_idx == IDX_SOF) begin
            cur_byte = SOF_BYTE;
        end else if (byte_idx == IDX_SEQ) begin
            cur_byte = seq;
        end else if (byte_idx == IDX_LAST) begin
            cur_byte = csum;
        end
    end

    // Next-state logic of the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (i_en && !i_fifo_empty && !i_tx_busy) state_nxt = ST_POP;
            ST_POP:       state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA: if (i_fifo_rdata_valid) state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = ST_STROBE;
            ST_STROBE:    state_nxt = ST_GUARD;
            ST_GUARD:     state_nxt = ST_WAIT_TX;
            ST_WAIT_TX:   if (!i_tx_busy) state_nxt = (byte_idx == IDX_LAST) ? ST_DONE : ST_LOAD;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // State register, byte index, running checksum, output byte and sequence number.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
            csum     <= '0;
            tx_data  <= '0;
            seq      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_WAIT_DATA: begin
                    if (i_fifo_rdata_valid) begin
                        byte_idx <= IDX_SOF;
                        csum     <= '0;
                    end
                end
                ST_LOAD: begin
                    tx_data <= cur_byte;
                    // Fold seq and data into the checksum as they go out, so it is ready in time.
                    if (byte_idx != IDX_SOF && byte_idx != IDX_LAST) begin
                        csum <= csum ^ cur_byte;
                    end
                end
                ST_WAIT_TX: begin
                    if (!i_tx_busy && byte_idx != IDX_LAST) begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                ST_DONE: seq <= seq + 8'd1;
                default: ;
            endcase
        end
    end

    // Sample shift register: loaded from the FIFO, shifted one byte after each data byte is loaded.
    always_ff @(posedge i_clk) begin
        // NOTE: no reset here; the register is always reloaded before use, and the FSM reset alone keeps it from being read.
        if (state == ST_WAIT_DATA && i_fifo_rdata_valid) begin
            shreg <= (NB*8)'(i_fifo_rdata);
        end else if (state == ST_LOAD && byte_idx > IDX_SEQ && byte_idx != IDX_LAST) begin
            shreg <= shreg << 8;
        end
    end

    // Outputs are forced low while reset is held so an aborted frame emits nothing more.
    assign o_fifo_pop      = !i_rst && (state == ST_POP);
    assign o_tx_data_valid = !i_rst && (state == ST_STROBE);
    assign o_busy          = !i_rst && (state != ST_IDLE);
    assign o_frame_done    = !i_rst && (state == ST_DONE);
    assign o_tx_data       = i_rst ? 8'h00 : tx_data;
    assign o_seq           = i_rst ? 8'h00 : seq;

endmodule
